// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract unit.
// One 1-bit full-adder slice is reused over WIDTH cycles, LSB first.
// Operands sit in right-shifting registers. Each result bit enters the
// sum register at its MSB end, so after WIDTH shifts the result is in
// the correct bit order. A subtract is done as A + ~B + 1: the
// inverted B is latched and the carry flop is preset to 1.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // The counter must hold WIDTH without wrapping. It is only ever
  // compared against WIDTH-1.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Shared full-adder slice and last-step detection.
  logic slice_s;
  logic slice_c;
  logic last_step;

  // The single full-adder slice, fed by the operand LSBs and the carry flop.
  always_comb begin
    slice_s   = opa_q[0] ^ opb_q[0] ^ carry_q;
    slice_c   = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state and next-datapath logic. busy and done are computed from
  // the state being entered, so that they come out of flops.
  always_comb begin
    // NOTE: every signal gets a default first. A path that leaves one
    // unassigned would infer a latch.
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        // Shift right and insert the new bit at the MSB. Written this way
        // so the shift stays legal when WIDTH is 1.
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = slice_s;
        opa_d            = opa_q >> 1;
        opb_d            = opb_q >> 1;
        carry_d          = slice_c;
        cnt_d            = cnt_q + CNT_W'(1);
        if (last_step) begin
          cout_d  = slice_c;
          // On the MSB step, carry_q is the carry into the MSB.
          ovf_d   = carry_q ^ slice_c;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset. A reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the values from before this edge.
    if (rst) begin
      // NOTE: the operand, carry and counter flops are also cleared. They
      // are reloaded on every accepting edge, but clearing them keeps the
      // idle datapath deterministic after power-up.
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add/subtract unit. One shared 1-bit full-adder slice (sum = a^b^cin, cout = majority) is reused over WIDTH clock cycles, LSB first.
- The block holds the FSM, operand shift registers, carry flip-flop, bit counter and start/done handshake around that slice.
- It sits in the lab ALU path as the area-minimal alternative to a ripple-carry adder. The same block also serves as a demonstration of datapath sequencing.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- start  input  1  request; accepted only on an edge where state is IDLE.
- a  input  WIDTH  operand A; sampled only on the accepting edge.
- b  input  WIDTH  operand B; sampled only on the accepting edge.
- sub  input  1  0 = A+B, 1 = A-B; sampled only on the accepting edge.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse, high while state is DONE.
- sum  output  WIDTH  result register.
- cout  output  1  final carry out (for subtract: 1 = no borrow).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free; state must be registered.
- Reset (rst=1 at an edge, any state):
  - next state IDLE;
  - sum=0, cout=0, ovf=0;
  - busy=0, done=0 in the following cycle.
  - Reset wins over start on the same edge.
- Reset mid-RUN aborts the operation: no done pulse, partial result discarded, outputs zero.
- IDLE with start=1 at edge E0:
  - latch opA=a, opB = sub ? ~b : b;
  - carry = sub;
  - bit counter = 0;
  - clear sum, cout, ovf;
  - go to RUN.
- IDLE with start=0: hold all outputs (the previous result stays visible).
- RUN, each edge Ek (k = 1..WIDTH):
  - slice inputs are opA[0], opB[0], carry;
  - sum bit is shifted into sum from the MSB end, so after WIDTH shifts sum holds the LSB-first result in correct order;
  - opA and opB shift right by 1;
  - carry <= slice cout;
  - counter increments.
- At edge E_WIDTH:
  - cout <= slice cout;
  - ovf <= carry-in of this (MSB) step XOR slice cout;
  - go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; unconditionally go to IDLE on the next edge.
- start in RUN or DONE is ignored; it is not queued.
- Latency:
  - done is high in the cycle after edge E_WIDTH.
  - The next start can be accepted at edge E_{WIDTH+2} at earliest.
  - Throughput is one operation per WIDTH+2 cycles.
- a, b and sub may change freely after the accepting edge without affecting the result.
- sum, cout and ovf are stable from done until the next accepted start.
- During RUN, sum shows partial shift contents and must not be used.
- Arithmetic:
  - sum = (A + B) mod 2^WIDTH, or (A + ~B + 1) mod 2^WIDTH for subtract;
  - cout is bit WIDTH of that unbounded sum.
- WIDTH=1: RUN lasts one cycle; ovf = cin XOR cout of the single step.
- Counter width is clog2(WIDTH+1). The counter must not wrap before the DONE transition.

Test Plan:
- WIDTH=8, add 0x35+0x4A, start pulsed 1 cycle -> busy for 8 cycles, done at 9th cycle after accepting edge, sum=0x7F, cout=0, ovf=0.
- Add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0. Add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
- Subtract 0x10-0x20 -> sum=0xF0, cout=0, ovf=0. Subtract 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
- Start 0x12+0x34, change a/b to 0xFF and hold start=1 throughout RUN -> sum=0x46, and no second operation begins until IDLE. With start still high in IDLE, the next op begins at edge E_{10} with the new operands.
- Assert rst for 1 cycle after 4 RUN cycles -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0. No done pulse occurs; a subsequent 0x01+0x01 yields 0x02.
- WIDTH=4 exhaustive: all a, b in 0..15, both sub values (512 ops) -> sum/cout/ovf match a behavioural +/- model. done is exactly one cycle wide every time.
